// File: rtl/vga_pkg.sv
// Shared definitions for the VGA CPU register controller.
//   - register addresses on the 2-bit CPU address bus
//   - CTRL bit positions
//   - STATUS read-back layout and a packing helper
package vga_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_BGCOL  = 2'd1;
  localparam logic [1:0] REG_FGCOL  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN    = 0;  // display enable
  localparam int CTRL_BLINK = 1;  // blink enable
  localparam int CTRL_IMM   = 6;  // commit writes immediately, not at vblank
  localparam int CTRL_IRQ   = 7;  // vblank interrupt enable

  localparam int ST_VSYNC   = 0;
  localparam int ST_BLINK   = 1;
  localparam int ST_VBLANK  = 6;
  localparam int ST_PENDING = 7;

  typedef struct packed {
    logic       pending;
    logic       vblank;
    logic [3:0] rsvd;
    logic       blink;
    logic       vsync;
  } status_t;

  function automatic logic [7:0] status_pack(input logic pending, input logic vblank,
                                             input logic blink, input logic vsync);
    status_t s;
    s = '{pending, vblank, 4'b0, blink, vsync};
    return s;
  endfunction

endpackage

// File: rtl/vga_reg_ctrl_if.sv
// CPU-side bus of the VGA register controller (8086 style I/O cycle).
//   addr     : register select, stable for the whole strobe
//   _vga_io  : active-low chip select (asynchronous)
//   _wr/_rd  : active-low write/read strobes (asynchronous)
//   data_in  : write data from the CPU
//   data_out : read data to the CPU, qualified by data_oe
//   data_oe  : enable for the external data bus tristate
interface vga_reg_ctrl_if;
  logic [1:0] addr;
  logic       _vga_io;
  logic       _wr;
  logic       _rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output addr, _vga_io, _wr, _rd, data_in,
                  input  data_out, data_oe);
  modport slave  (input  addr, _vga_io, _wr, _rd, data_in,
                  output data_out, data_oe);
endinterface

// File: rtl/vga_strobe_sync.sv
// N-stage synchroniser for an active-low asynchronous strobe.
//   clk, reset : video clock, synchronous active-high reset
//   strobe_n   : asynchronous active-low strobe
//   active     : synced level of the strobe (1 = asserted)
//   fell       : one-cycle pulse on the synced falling edge of strobe_n
// A falling edge only counts after a genuine high sample has come through
// the chain since reset, so a strobe already low at reset release gives
// no pulse until it has been released and asserted again.
module vga_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic active,
  output logic fell
);

  logic [STAGES-1:0] sync_q, sync_d;
  // marks which chain stages hold real pin samples rather than reset values
  logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
  logic              armed_q, armed_d;
  logic              s, v;

  always_comb begin
    sync_d     = {sync_q[STAGES-2:0], strobe_n};
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], 1'b1};
    s          = sync_q[STAGES-1];
    v          = vld_pipe_q[STAGES-1];
    active     = ~s;
    fell       = armed_q & ~s;
    armed_d    = armed_q;
    if (!s)     armed_d = 1'b0;
    else if (v) armed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      vld_pipe_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
      armed_q    <= armed_d;
    end
  end

endmodule

// File: rtl/vga_reg_ctrl.sv
// CPU register controller for the VGA block.
//   clk, reset : video clock, synchronous active-high reset
//   bus        : CPU I/O bus (slave side), strobes asynchronous
//   vblank     : vertical blank, synchronous to clk
//   _char_bg   : 0 = background pixel, 1 = foreground pixel
//   dcol       : registered pixel colour
//   blink      : cursor/attribute blink phase
//   irq        : vblank interrupt, level
// CPU writes land in shadow registers and are copied to the live registers
// at the vblank rising edge (or the cycle after a write in IMMEDIATE mode),
// so the visible frame never changes mid-scan.
module vga_reg_ctrl
  import vga_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_reg_ctrl_if.slave        bus,
  input  logic                 vblank,
  input  logic                 _char_bg,
  output logic [7:0]           dcol,
  output logic                 blink,
  output logic                 irq
);

  logic wr_n, rd_n;
  logic wr_pulse, rd_active;
  logic wr_active_unused, rd_fell_unused;

  assign wr_n = bus._vga_io | bus._wr;
  assign rd_n = bus._vga_io | bus._rd;

  vga_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk, .reset, .strobe_n(wr_n), .active(wr_active_unused), .fell(wr_pulse)
  );
  vga_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk, .reset, .strobe_n(rd_n), .active(rd_active), .fell(rd_fell_unused)
  );

  logic [7:0] ctrl_sh_q, ctrl_sh_d, bgcol_sh_q, bgcol_sh_d, fgcol_sh_q, fgcol_sh_d;
  logic [7:0] ctrl_q, ctrl_d, bgcol_q, bgcol_d, fgcol_q, fgcol_d;
  logic       pending_q, pending_d, vsync_q, vsync_d, vblank_q, vblank_d;
  logic       imm_q, imm_d, blink_q, blink_d, data_oe_q, data_oe_d;
  logic [7:0] bcnt_q, bcnt_d, dcol_q, dcol_d, data_out_q, data_out_d;
  logic       vblank_rise, shadow_wr, status_clr, commit;
  logic [7:0] rd_data;

  always_comb begin
    vblank_d    = vblank;
    vblank_rise = vblank & ~vblank_q;

    ctrl_sh_d  = ctrl_sh_q;
    bgcol_sh_d = bgcol_sh_q;
    fgcol_sh_d = fgcol_sh_q;
    shadow_wr  = 1'b0;
    status_clr = 1'b0;
    if (wr_pulse) begin
      case (bus.addr)
        REG_CTRL:  begin ctrl_sh_d  = bus.data_in; shadow_wr = 1'b1; end
        REG_BGCOL: begin bgcol_sh_d = bus.data_in; shadow_wr = 1'b1; end
        REG_FGCOL: begin fgcol_sh_d = bus.data_in; shadow_wr = 1'b1; end
        default:   status_clr = bus.data_in[ST_VSYNC];
      endcase
    end

    // IMMEDIATE is judged on the shadow value before this write, so
    // toggling bit6 takes effect under the previous rule.
    imm_d  = shadow_wr & ctrl_sh_q[CTRL_IMM];
    commit = vblank_rise | imm_q;

    // commit takes the post-write shadow, forwarding a same-cycle write
    ctrl_d    = commit ? ctrl_sh_d  : ctrl_q;
    bgcol_d   = commit ? bgcol_sh_d : bgcol_q;
    fgcol_d   = commit ? fgcol_sh_d : fgcol_q;
    pending_d = commit ? 1'b0 : (pending_q | shadow_wr);

    // set wins over a simultaneous write-1-to-clear
    vsync_d = vblank_rise ? 1'b1 : (status_clr ? 1'b0 : vsync_q);

    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (!ctrl_q[CTRL_BLINK]) begin
      bcnt_d  = 8'd0;
      blink_d = 1'b0;
    end else if (vblank_rise) begin
      if (bcnt_q == 8'(BLINK_FRAMES - 1)) begin
        bcnt_d  = 8'd0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 8'd1;
      end
    end

    dcol_d = ctrl_q[CTRL_EN] ? (_char_bg ? fgcol_q : bgcol_q) : 8'h00;

    case (bus.addr)
      REG_CTRL:  rd_data = ctrl_q;
      REG_BGCOL: rd_data = bgcol_q;
      REG_FGCOL: rd_data = fgcol_q;
      default:   rd_data = status_pack(pending_q, vblank, blink_q, vsync_q);
    endcase
    data_oe_d  = rd_active;
    data_out_d = rd_active ? rd_data : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_sh_q  <= '0;  bgcol_sh_q <= '0;  fgcol_sh_q <= '0;
      ctrl_q     <= '0;  bgcol_q    <= '0;  fgcol_q    <= '0;
      pending_q  <= 1'b0; vsync_q   <= 1'b0; vblank_q  <= 1'b0;
      imm_q      <= 1'b0; blink_q   <= 1'b0; data_oe_q <= 1'b0;
      bcnt_q     <= '0;  dcol_q     <= '0;  data_out_q <= '0;
    end else begin
      ctrl_sh_q  <= ctrl_sh_d;  bgcol_sh_q <= bgcol_sh_d;  fgcol_sh_q <= fgcol_sh_d;
      ctrl_q     <= ctrl_d;     bgcol_q    <= bgcol_d;     fgcol_q    <= fgcol_d;
      pending_q  <= pending_d;  vsync_q    <= vsync_d;     vblank_q   <= vblank_d;
      imm_q      <= imm_d;      blink_q    <= blink_d;     data_oe_q  <= data_oe_d;
      bcnt_q     <= bcnt_d;     dcol_q     <= dcol_d;      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign dcol         = dcol_q;
  assign blink        = blink_q;
  assign irq          = vsync_q & ctrl_q[CTRL_IRQ];

endmodule
